// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and byte-lane helpers for dmem_responder
package dmem_pkg;

   localparam int unsigned LANES = 8;

   typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

   // Offset bits that must be zero for an access of this size to be aligned.
   function automatic logic [2:0] align_mask(input size_e sz);
      case (sz)
         SZ_B:    return 3'b000;
         SZ_H:    return 3'b001;
         SZ_W:    return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

   function automatic logic [LANES-1:0] byte_enable(input size_e sz, input logic [2:0] off);
      logic [LANES-1:0] m;
      case (sz)
         SZ_B:    m = 8'h01;
         SZ_H:    m = 8'h03;
         SZ_W:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m << off;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - load shift/mask/extend and store replication/byte-enable
// Offsets are expected to be aligned to the access size on the store path.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [63:0] rd_word,
   input  logic [2:0]  offset,
   input  size_e       size,
   input  logic        is_unsigned,
   input  logic [63:0] wdata,
   output logic [63:0] ld_data,
   output logic [63:0] st_data,
   output logic [7:0]  byte_en
);

   logic [63:0] shifted;

   always_comb begin
      shifted = rd_word >> {offset, 3'b000};
      ld_data = shifted;
      st_data = wdata;
      case (size)
         SZ_B: begin
            ld_data = is_unsigned ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
            st_data = {8{wdata[7:0]}};
         end
         SZ_H: begin
            ld_data = is_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            st_data = {4{wdata[15:0]}};
         end
         SZ_W: begin
            ld_data = is_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            st_data = {2{wdata[31:0]}};
         end
         default: begin
            ld_data = shifted;
            st_data = wdata;
         end
      endcase
   end

   assign byte_en = byte_enable(size, offset);

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked load/store data memory with fixed access latency
// Optional misalignment error reporting: DMEM_MISALIGN_CHECK_EN (otherwise addresses align down).
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int DM_ADDRESS = 9,
   parameter int LAT        = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [DM_ADDRESS-1:0] req_addr,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err
);

   localparam int WORDS = 2 ** (DM_ADDRESS - 3);
   localparam logic [3:0] LAT_M1 = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

   state_e state, next_state;
   logic [3:0] cnt;
   logic accept, commit, do_write, err_c;

   logic                  lat_we, lat_unsigned;
   logic [DM_ADDRESS-1:0] lat_addr;
   size_e                 lat_size;
   logic [DATA_W-1:0]     lat_wdata;

   logic                  cur_we, cur_unsigned;
   logic [DM_ADDRESS-1:0] cur_addr, eff_addr;
   size_e                 cur_size;
   logic [DATA_W-1:0]     cur_wdata;

   logic [63:0] mem [WORDS];
   logic [63:0] rd_word, ld_data, st_data;
   logic [7:0]  byte_en;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (req_valid) next_state = (LAT > 0) ? WAIT : RESP;
         WAIT:    if (cnt == 4'd0) next_state = RESP;
         RESP:    if (rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE) && !reset;
   end

   assign accept = req_valid && req_ready;
   assign commit = (state != RESP) && (next_state == RESP) && !reset;

   always_ff @(posedge clk) begin
      if (reset)                        cnt <= 4'd0;
      else if (accept)                  cnt <= LAT_M1;
      else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lat_we       <= req_we;
         lat_addr     <= req_addr;
         lat_size     <= size_e'(req_size);
         lat_unsigned <= req_unsigned;
         lat_wdata    <= req_wdata;
      end
   end

   // With zero latency the commit happens on the accepting edge, so use live request fields.
   always_comb begin
      if (state == IDLE) begin
         cur_we       = req_we;
         cur_addr     = req_addr;
         cur_size     = size_e'(req_size);
         cur_unsigned = req_unsigned;
         cur_wdata    = req_wdata;
      end else begin
         cur_we       = lat_we;
         cur_addr     = lat_addr;
         cur_size     = lat_size;
         cur_unsigned = lat_unsigned;
         cur_wdata    = lat_wdata;
      end
   end

`ifdef DMEM_MISALIGN_CHECK_EN
   assign eff_addr = cur_addr;
   assign err_c    = |(cur_addr[2:0] & align_mask(cur_size));
`else
   assign eff_addr = {cur_addr[DM_ADDRESS-1:3], cur_addr[2:0] & ~align_mask(cur_size)};
   assign err_c    = 1'b0;
`endif

   assign rd_word  = mem[eff_addr[DM_ADDRESS-1:3]];
   assign do_write = commit && cur_we && !err_c;

   dmem_lane_align u_lane (
      .rd_word     (rd_word),
      .offset      (eff_addr[2:0]),
      .size        (cur_size),
      .is_unsigned (cur_unsigned),
      .wdata       (cur_wdata),
      .ld_data     (ld_data),
      .st_data     (st_data),
      .byte_en     (byte_en)
   );

   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int i = 0; i < LANES; i++) begin
            if (byte_en[i]) mem[eff_addr[DM_ADDRESS-1:3]][8*i +: 8] <= st_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (commit) begin
         rsp_valid <= 1'b1;
         rsp_rdata <= (cur_we || err_c) ? '0 : ld_data;
         rsp_err   <= err_c;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

   localparam int DATA_W     = 64;
   localparam int DM_ADDRESS = 9;
   localparam int LAT        = 2;
   localparam int NBYTES     = 2 ** DM_ADDRESS;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b0;
   logic [DM_ADDRESS-1:0] req_addr = '0;
   logic [1:0] req_size = 2'd0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic req_ready, rsp_valid, rsp_err;
   logic [DATA_W-1:0] rsp_rdata;

   int checks = 0;
   int failures = 0;
   logic [7:0] ref_mem [NBYTES];

   always #5 clk = ~clk;

   dmem_responder #(.DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS), .LAT(LAT)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err)
   );

   // Byte-array view of memory: an access touches 2**size bytes from its (aligned) base.
   function automatic void model_access(input logic we, input int addr, input int sz, input logic uns,
                                        input logic [63:0] wd, output logic [63:0] rd, output logic er);
      int nb;
      int base;
      nb   = 1 << sz;
      base = addr - (addr % nb);
      rd   = '0;
      er   = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
      if (addr % nb != 0) begin
         er = 1'b1;
         return;
      end
`endif
      if (we) begin
         for (int i = 0; i < nb; i++) ref_mem[base + i] = wd[8*i +: 8];
      end else begin
         for (int i = 0; i < nb; i++) rd[8*i +: 8] = ref_mem[base + i];
         if (!uns && nb < 8 && rd[8*nb - 1]) rd = rd | (~64'd0 << (8 * nb));
      end
   endfunction

   task automatic issue(input logic we, input int addr, input int sz, input logic uns, input logic [63:0] wd,
                        output logic [63:0] rd, output logic er, output int cyc);
      int n;
      req_we = we;
      req_addr = addr[DM_ADDRESS-1:0];
      req_size = sz[1:0];
      req_unsigned = uns;
      req_wdata = wd;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++; failures++;
         $display("FAIL req_ready_timeout: req_ready=%b required=1", req_ready);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!rsp_valid && cyc < 40);
      rd = rsp_rdata;
      er = rsp_err;
      if (!rsp_valid) begin
         checks++; failures++;
         $display("FAIL rsp_timeout: rsp_valid=%b required=1", rsp_valid);
      end
   endtask

   task automatic complete();
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      checks++; if (rsp_rdata !== 64'd0) begin failures++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_req_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_fill();
      logic [63:0] wd, rd, erd;
      logic er, eer;
      int cyc;
      for (int w = 0; w < NBYTES / 8; w++) begin
         wd = {$urandom, $urandom};
         model_access(1'b1, 8 * w, 3, 1'b0, wd, erd, eer);
         issue(1'b1, 8 * w, 3, 1'b0, wd, rd, er, cyc);
         checks++;
         if (rd !== erd || er !== eer) begin
            failures++;
            $display("FAIL fill_store[%0d]: got rdata=%h err=%b want rdata=%h err=%b", w, rd, er, erd, eer);
         end
         complete();
      end
   endtask

   task automatic test_store_load();
      logic [63:0] rd, erd;
      logic er, eer;
      int cyc;
      model_access(1'b1, 'h010, 3, 1'b0, 64'h1122334455667788, erd, eer);
      issue(1'b1, 'h010, 3, 1'b0, 64'h1122334455667788, rd, er, cyc);
      checks++; if (rd !== 64'd0 || er !== 1'b0) begin failures++; $display("FAIL store_d_rsp: got rdata=%h err=%b want 0/0", rd, er); end
      complete();
      model_access(1'b0, 'h010, 3, 1'b0, 64'd0, erd, eer);
      issue(1'b0, 'h010, 3, 1'b0, 64'd0, rd, er, cyc);
      checks++; if (rd !== 64'h1122334455667788) begin failures++; $display("FAIL load_d_data: got %h want 1122334455667788", rd); end
      checks++; if (er !== 1'b0) begin failures++; $display("FAIL load_d_err: got %b want 0", er); end
      checks++; if (cyc != LAT + 1) begin failures++; $display("FAIL load_latency: got %0d want %0d", cyc, LAT + 1); end
      complete();
   endtask

   task automatic test_lane_ext();
      logic [63:0] rd, erd;
      logic er, eer;
      int cyc;
      model_access(1'b0, 'h017, 0, 1'b0, 64'd0, erd, eer);
      issue(1'b0, 'h017, 0, 1'b0, 64'd0, rd, er, cyc);
      checks++; if (rd !== 64'h0000000000000011) begin failures++; $display("FAIL ldb_s_17: got %h want 0000000000000011", rd); end
      complete();
      model_access(1'b1, 'h011, 0, 1'b0, 64'h80, erd, eer);
      issue(1'b1, 'h011, 0, 1'b0, 64'h80, rd, er, cyc);
      complete();
      issue(1'b0, 'h011, 0, 1'b0, 64'd0, rd, er, cyc);
      checks++; if (rd !== 64'hFFFFFFFFFFFFFF80) begin failures++; $display("FAIL ldb_s_11: got %h want FFFFFFFFFFFFFF80", rd); end
      complete();
      issue(1'b0, 'h011, 0, 1'b1, 64'd0, rd, er, cyc);
      checks++; if (rd !== 64'h0000000000000080) begin failures++; $display("FAIL ldb_u_11: got %h want 0000000000000080", rd); end
      complete();
   endtask

   task automatic test_backpressure();
      logic [63:0] rd, erd;
      logic er, eer;
      int cyc;
      model_access(1'b0, 'h010, 3, 1'b0, 64'd0, erd, eer);
      issue(1'b0, 'h010, 3, 1'b0, 64'd0, rd, er, cyc);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== erd || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL backpressure[%0d]: got valid=%b rdata=%h req_ready=%b want 1/%h/0", k, rsp_valid, rsp_rdata, req_ready, erd);
         end
      end
      complete();
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL release: got req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_misalign();
      logic [63:0] rd, erd;
      logic er, eer;
      int cyc;
      model_access(1'b1, 'h012, 2, 1'b0, 64'hDEADBEEF, erd, eer);
      issue(1'b1, 'h012, 2, 1'b0, 64'hDEADBEEF, rd, er, cyc);
      checks++; if (er !== eer || rd !== 64'd0) begin failures++; $display("FAIL misalign_store: got err=%b rdata=%h want %b/0", er, rd, eer); end
      complete();
      model_access(1'b0, 'h010, 2, 1'b0, 64'd0, erd, eer);
      issue(1'b0, 'h010, 2, 1'b0, 64'd0, rd, er, cyc);
      checks++; if (rd !== erd || er !== 1'b0) begin failures++; $display("FAIL misalign_reload: got %h err=%b want %h/0", rd, er, erd); end
`ifndef DMEM_MISALIGN_CHECK_EN
      checks++; if (rd !== 64'hFFFFFFFFDEADBEEF) begin failures++; $display("FAIL aligned_down_load: got %h want FFFFFFFFDEADBEEF", rd); end
`endif
      complete();
   endtask

   task automatic test_reset_mid();
      logic [63:0] rd, erd;
      logic er, eer;
      int cyc;
      req_we = 1'b1; req_addr = 'h020; req_size = 2'd0; req_unsigned = 1'b1; req_wdata = 64'hAA;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (LAT) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 64'd0) begin failures++; $display("FAIL mid_reset_rsp: got valid=%b rdata=%h want 0/0", rsp_valid, rsp_rdata); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_req_ready: got %b want 1", req_ready); end
      model_access(1'b0, 'h020, 0, 1'b1, 64'd0, erd, eer);
      issue(1'b0, 'h020, 0, 1'b1, 64'd0, rd, er, cyc);
      checks++; if (rd !== erd) begin failures++; $display("FAIL discarded_store: got %h want %h", rd, erd); end
      complete();
   endtask

   task automatic test_random();
      logic [63:0] wd, rd, erd;
      logic er, eer, we, uns;
      int addr, sz, cyc;
      for (int n = 0; n < 80; n++) begin
         we   = 1'($urandom_range(0, 1));
         uns  = 1'($urandom_range(0, 1));
         sz   = int'($urandom_range(0, 3));
         addr = int'($urandom_range(0, NBYTES - 1));
         wd   = {$urandom, $urandom};
         model_access(we, addr, sz, uns, wd, erd, eer);
         issue(we, addr, sz, uns, wd, rd, er, cyc);
         checks++;
         if (rd !== erd || er !== eer || cyc != LAT + 1) begin
            failures++;
            $display("FAIL random[%0d] we=%b addr=%h sz=%0d uns=%b: got rdata=%h err=%b lat=%0d want %h/%b/%0d",
                     n, we, addr, sz, uns, rd, er, cyc, erd, eer, LAT + 1);
         end
         complete();
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_store_load();
      test_lane_ext();
      test_backpressure();
      test_misalign();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
